// File: rtl/pmp_check_trap_unit_if.sv
// Bus bundle between the core and the PMP check/trap unit.
// master: core side (CSR access, check requests, trap acknowledge).
// slave:  PMP unit side (read data, check results, trap handshake, counter).
interface pmp_check_trap_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  csr_write;
    logic                  csr_sel;
    logic [3:0]            csr_index;
    logic [ADDR_WIDTH-1:0] csr_wdata;
    logic [ADDR_WIDTH-1:0] csr_rdata;
    logic                  priv_m;
    logic                  instr_valid;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  data_valid;
    logic                  data_write;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  instr_pmp_ok;
    logic                  data_pmp_ok;
    logic                  stall;
    logic                  trap_req;
    logic                  trap_ack;
    logic [3:0]            trap_cause;
    logic [ADDR_WIDTH-1:0] trap_addr;
    logic [CNT_WIDTH-1:0]  violation_count;

    modport master (
        output csr_write, csr_sel, csr_index, csr_wdata, priv_m,
               instr_valid, instr_addr, data_valid, data_write, data_addr, trap_ack,
        input  csr_rdata, instr_pmp_ok, data_pmp_ok, stall, trap_req,
               trap_cause, trap_addr, violation_count
    );

    modport slave (
        input  csr_write, csr_sel, csr_index, csr_wdata, priv_m,
               instr_valid, instr_addr, data_valid, data_write, data_addr, trap_ack,
        output csr_rdata, instr_pmp_ok, data_pmp_ok, stall, trap_req,
               trap_cause, trap_addr, violation_count
    );
endinterface

// File: rtl/pmp_check_trap_unit.sv
// Physical memory protection checker with first-fault trap handshake.
// Ports: clk, rst_n (async active-low), bus (pmp_check_trap_unit_if.slave):
//   CSR write/read of pmpcfg/pmpaddr entries, fetch and data check requests,
//   registered per-port pass/fail, stall/trap request/ack, cause/address, counter.
// Optional macro PMP_VIOL_CNT_EN: enables the saturating violation counter;
// without it violation_count is tied to 0.
module pmp_check_trap_unit #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic                clk,
    input logic                rst_n,
    pmp_check_trap_unit_if.slave bus
);
    localparam int unsigned WW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, TRAP, DRAIN} state_t;

    logic [7:0]       cfg_q  [NUM_ENTRIES];
    logic [WW-1:0]    addr_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] addr_wlock;
    logic [NUM_ENTRIES-1:0] instr_hit, data_hit;
    logic             instr_ok_d, data_ok_d, instr_ok_q, data_ok_q;
    logic             instr_viol, data_viol;
    state_t           state_q, state_d;
    logic [3:0]       cause_d, cause_q;
    logic [ADDR_WIDTH-1:0] taddr_d, taddr_q;
    logic             trap_req_q, stall_q;
    logic             unused_bits;

    assign unused_bits = ^{bus.instr_addr[1:0], bus.data_addr[1:0],
                           bus.csr_wdata[ADDR_WIDTH-1:WW]};

    // Region match for entry i against word address a.
    function automatic logic entry_match(input int unsigned i, input logic [WW-1:0] a);
        logic [WW-1:0] lo, hi, care;
        logic m;
        hi   = addr_q[i];
        lo   = '0;
        if (i != 0) lo = addr_q[i-1];
        // NAPOT: trailing ones plus the next bit are don't-care
        care = ~(hi ^ (hi + WW'(1)));
        case (cfg_q[i][4:3])
            2'd1:    m = (lo < hi) && (a >= lo) && (a < hi);
            2'd2:    m = (a == hi);
            2'd3:    m = ((a ^ hi) & care) == '0;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Lowest-index hit decides; unlocked entries do not restrict M-mode.
    function automatic logic decide(input logic [NUM_ENTRIES-1:0] hit,
                                    input logic [2:0] need, input logic priv);
        logic found, allow;
        found = 1'b0;
        allow = priv;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!found && hit[i]) begin
                found = 1'b1;
                allow = (priv && !cfg_q[i][7]) ? 1'b1 : |(cfg_q[i][2:0] & need);
            end
        end
        return allow;
    endfunction

    // pmpaddr write protection: own lock, or next entry locked as TOR
    always_comb begin
        addr_wlock = '0;
        for (int unsigned i = 0; i + 1 < NUM_ENTRIES; i++)
            addr_wlock[i] = cfg_q[i][7] | (cfg_q[i+1][7] & (cfg_q[i+1][4:3] == 2'd1));
        addr_wlock[NUM_ENTRIES-1] = cfg_q[NUM_ENTRIES-1][7];
    end

    // CSR storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (bus.csr_write) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (bus.csr_index == 4'(i)) begin
                    if (!bus.csr_sel && !cfg_q[i][7])
                        cfg_q[i] <= bus.csr_wdata[7:0] & 8'h9F;
                    if (bus.csr_sel && !addr_wlock[i])
                        addr_q[i] <= bus.csr_wdata[WW-1:0];
                end
            end
        end
    end

    // CSR read
    always_comb begin
        bus.csr_rdata = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (bus.csr_index == 4'(i))
                bus.csr_rdata = bus.csr_sel ? {2'b00, addr_q[i]} : ADDR_WIDTH'(cfg_q[i]);
        end
    end

    // Access checks
    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            instr_hit[i] = entry_match(i, bus.instr_addr[ADDR_WIDTH-1:2]);
            data_hit[i]  = entry_match(i, bus.data_addr[ADDR_WIDTH-1:2]);
        end
        instr_ok_d = !bus.instr_valid || decide(instr_hit, 3'b100, bus.priv_m);
        data_ok_d  = !bus.data_valid ||
                     decide(data_hit, bus.data_write ? 3'b010 : 3'b001, bus.priv_m);
        instr_viol = !instr_ok_d;
        data_viol  = !data_ok_d;
    end

    // Trap FSM next state; violations are seen as they are registered
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        taddr_d = taddr_q;
        case (state_q)
            IDLE: begin
                if (data_viol) begin
                    cause_d = bus.data_write ? 4'd7 : 4'd5;
                    taddr_d = bus.data_addr;
                    state_d = TRAP;
                end else if (instr_viol) begin
                    cause_d = 4'd1;
                    taddr_d = bus.instr_addr;
                    state_d = TRAP;
                end
            end
            TRAP:    if (bus.trap_ack) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered results and trap state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cause_q    <= '0;
            taddr_q    <= '0;
            instr_ok_q <= 1'b1;
            data_ok_q  <= 1'b1;
            trap_req_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            taddr_q    <= taddr_d;
            instr_ok_q <= instr_ok_d;
            data_ok_q  <= data_ok_d;
            trap_req_q <= (state_d == TRAP);
            stall_q    <= (state_d != IDLE);
        end
    end

`ifdef PMP_VIOL_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating count of cycles with any violation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if ((instr_viol || data_viol) && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    assign bus.violation_count = cnt_q;
`else
    assign bus.violation_count = '0;
`endif

    assign bus.instr_pmp_ok = instr_ok_q;
    assign bus.data_pmp_ok  = data_ok_q;
    assign bus.trap_req     = trap_req_q;
    assign bus.stall        = stall_q;
    assign bus.trap_cause   = cause_q;
    assign bus.trap_addr    = taddr_q;
endmodule

// File: tb/tb_pmp_check_trap_unit.sv
// Self-checking bench for pmp_check_trap_unit: reference model plus a
// scoreboard queue of expected check results popped one cycle after driving.
module tb_pmp_check_trap_unit;
    localparam int unsigned N  = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmp_check_trap_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
    pmp_check_trap_unit #(.NUM_ENTRIES(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_cfg  [N];
    logic [29:0] m_addr [N];
    int unsigned m_cnt;
    logic [1:0]  sb_q [$];

    function automatic bit m_match(int i, logic [29:0] a);
        logic [29:0] lo;
        int k;
        case (m_cfg[i][4:3])
            2'd1: begin
                lo = (i == 0) ? 30'd0 : m_addr[i-1];
                return (lo < m_addr[i]) && (a >= lo) && (a < m_addr[i]);
            end
            2'd2: return a == m_addr[i];
            2'd3: begin
                k = 0;
                while (k < 30 && m_addr[i][k]) k++;
                if (k >= 29) return 1'b1;
                return (a >> (k + 1)) == (m_addr[i] >> (k + 1));
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_allow(logic [29:0] a, int p, bit priv);
        for (int i = 0; i < int'(N); i++)
            if (m_match(i, a)) return (priv && !m_cfg[i][7]) ? 1'b1 : m_cfg[i][p];
        return priv;
    endfunction

    function automatic logic [31:0] m_read(bit sel, int idx);
        if (idx >= int'(N)) return 32'd0;
        return sel ? {2'b00, m_addr[idx]} : {24'd0, m_cfg[idx]};
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef PMP_VIOL_CNT_EN
        return 16'(m_cnt);
`else
        return 16'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.csr_write = 0; bus.csr_sel = 0; bus.csr_index = 0; bus.csr_wdata = 0;
        bus.priv_m = 0; bus.instr_valid = 0; bus.instr_addr = 0;
        bus.data_valid = 0; bus.data_write = 0; bus.data_addr = 0; bus.trap_ack = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(N); i++) begin
            m_cfg[i] = 0;
            m_addr[i] = 0;
        end
        m_cnt = 0;
        sb_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        model_clear();
    endtask

    task automatic csr_wr(bit sel, int idx, logic [31:0] d);
        bit drop;
        bus.csr_write = 1; bus.csr_sel = sel; bus.csr_index = 4'(idx); bus.csr_wdata = d;
        if (idx < int'(N)) begin
            drop = m_cfg[idx][7];
            if (sel && idx + 1 < int'(N) && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'd1)
                drop = 1;
            if (!drop) begin
                if (sel) m_addr[idx] = d[29:0];
                else     m_cfg[idx] = d[7:0] & 8'h9F;
            end
        end
        step();
        bus.csr_write = 0;
    endtask

    task automatic csr_look(bit sel, int idx);
        bus.csr_sel = sel; bus.csr_index = 4'(idx);
        #1;
    endtask

    // One check cycle; expected Ok pair goes through the scoreboard
    task automatic access(bit priv, bit iv, logic [31:0] ia, bit dv, bit dw, logic [31:0] da);
        bit ei, ed;
        logic [1:0] e;
        bus.priv_m = priv; bus.instr_valid = iv; bus.instr_addr = ia;
        bus.data_valid = dv; bus.data_write = dw; bus.data_addr = da;
        ei = !iv || m_allow(ia[31:2], 2, priv);
        ed = !dv || m_allow(da[31:2], dw ? 1 : 0, priv);
        if ((!ei || !ed) && m_cnt != 32'hFFFF) m_cnt++;
        sb_q.push_back({ei, ed});
        step();
        e = sb_q.pop_front();
        checks++;
        if (bus.instr_pmp_ok !== e[1]) begin
            failures++;
            $display("FAIL instr_ok ia=%h got=%b exp=%b", ia, bus.instr_pmp_ok, e[1]);
        end
        checks++;
        if (bus.data_pmp_ok !== e[0]) begin
            failures++;
            $display("FAIL data_ok da=%h got=%b exp=%b", da, bus.data_pmp_ok, e[0]);
        end
        bus.instr_valid = 0; bus.data_valid = 0;
    endtask

    task automatic finish_trap();
        bus.trap_ack = 1;
        step();
        bus.trap_ack = 0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.instr_pmp_ok, bus.data_pmp_ok, bus.stall, bus.trap_req} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1100",
                     {bus.instr_pmp_ok, bus.data_pmp_ok, bus.stall, bus.trap_req});
        end
        checks++;
        if (bus.trap_cause !== 4'd0 || bus.trap_addr !== 32'd0 || bus.violation_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_regs cause=%0d addr=%h cnt=%0d exp=0", bus.trap_cause,
                     bus.trap_addr, bus.violation_count);
        end
        csr_look(1, 3);
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_csr got=%h exp=0", bus.csr_rdata);
        end
    endtask

    task automatic test_no_entry_trap();
        access(0, 1, 32'h100, 0, 0, 0);
        checks++;
        if (bus.trap_req !== 1 || bus.stall !== 1 || bus.trap_cause !== 4'd1 || bus.trap_addr !== 32'h100) begin
            failures++;
            $display("FAIL first_trap req=%b stall=%b cause=%0d addr=%h exp=1 1 1 00000100",
                     bus.trap_req, bus.stall, bus.trap_cause, bus.trap_addr);
        end
        step();
        checks++;
        if (bus.trap_req !== 1 || bus.stall !== 1) begin
            failures++;
            $display("FAIL trap_hold req=%b stall=%b exp=1 1", bus.trap_req, bus.stall);
        end
        bus.trap_ack = 1;
        step();
        bus.trap_ack = 0;
        checks++;
        if (bus.trap_req !== 0 || bus.stall !== 1) begin
            failures++;
            $display("FAIL drain req=%b stall=%b exp=0 1", bus.trap_req, bus.stall);
        end
        step();
        checks++;
        if (bus.stall !== 0 || bus.trap_req !== 0) begin
            failures++;
            $display("FAIL back_idle stall=%b req=%b exp=0 0", bus.stall, bus.trap_req);
        end
        bus.trap_ack = 1;
        step();
        bus.trap_ack = 0;
        checks++;
        if (bus.stall !== 0 || bus.trap_req !== 0) begin
            failures++;
            $display("FAIL stray_ack stall=%b req=%b exp=0 0", bus.stall, bus.trap_req);
        end
        checks++;
        if (bus.violation_count !== exp_cnt()) begin
            failures++;
            $display("FAIL count1 got=%0d exp=%0d", bus.violation_count, exp_cnt());
        end
    endtask

    task automatic test_tor();
        csr_wr(0, 0, 32'h09);
        csr_wr(1, 0, 32'h400);
        csr_look(0, 0);
        checks++;
        if (bus.csr_rdata !== m_read(0, 0)) begin
            failures++;
            $display("FAIL cfg0_read got=%h exp=%h", bus.csr_rdata, m_read(0, 0));
        end
        access(0, 0, 0, 1, 0, 32'hFFC);
        checks++;
        if (bus.trap_req !== 0) begin
            failures++;
            $display("FAIL tor_inside_trap req=%b exp=0", bus.trap_req);
        end
        access(0, 0, 0, 1, 0, 32'h1000);
        checks++;
        if (bus.trap_cause !== 4'd5 || bus.trap_addr !== 32'h1000) begin
            failures++;
            $display("FAIL tor_top cause=%0d addr=%h exp=5 00001000", bus.trap_cause, bus.trap_addr);
        end
        finish_trap();
        access(0, 0, 0, 1, 1, 32'h800);
        checks++;
        if (bus.trap_cause !== 4'd7 || bus.trap_addr !== 32'h800) begin
            failures++;
            $display("FAIL tor_store cause=%0d addr=%h exp=7 00000800", bus.trap_cause, bus.trap_addr);
        end
        finish_trap();
        checks++;
        if (bus.stall !== 0 || bus.trap_cause !== 4'd7 || bus.trap_addr !== 32'h800) begin
            failures++;
            $display("FAIL cause_hold stall=%b cause=%0d addr=%h exp=0 7 00000800",
                     bus.stall, bus.trap_cause, bus.trap_addr);
        end
    endtask

    task automatic test_priority();
        csr_wr(1, 1, 32'h1FF);
        csr_wr(0, 1, 32'h1F);
        csr_wr(0, 0, 32'h11);
        csr_wr(1, 0, 32'h200);
        access(0, 0, 0, 1, 1, 32'h800);
        checks++;
        if (bus.trap_req !== 1 || bus.trap_cause !== 4'd7 || bus.trap_addr !== 32'h800) begin
            failures++;
            $display("FAIL prio_na4 req=%b cause=%0d addr=%h exp=1 7 00000800",
                     bus.trap_req, bus.trap_cause, bus.trap_addr);
        end
        finish_trap();
        access(0, 1, 32'hFF8, 1, 1, 32'h804);
        checks++;
        if (bus.trap_req !== 0) begin
            failures++;
            $display("FAIL prio_napot req=%b exp=0", bus.trap_req);
        end
    endtask

    task automatic test_lock();
        csr_wr(1, 2, 32'h500);
        csr_wr(0, 2, 32'h90);
        csr_wr(0, 2, 32'h07);
        csr_wr(1, 2, 32'h999);
        csr_look(0, 2);
        checks++;
        if (bus.csr_rdata !== 32'h90) begin
            failures++;
            $display("FAIL lock_cfg got=%h exp=00000090", bus.csr_rdata);
        end
        csr_look(1, 2);
        checks++;
        if (bus.csr_rdata !== 32'h500) begin
            failures++;
            $display("FAIL lock_addr got=%h exp=00000500", bus.csr_rdata);
        end
        csr_wr(1, 3, 32'h600);
        csr_wr(1, 4, 32'h700);
        csr_wr(0, 4, 32'h8F);
        csr_wr(1, 3, 32'h123);
        csr_look(1, 3);
        checks++;
        if (bus.csr_rdata !== m_read(1, 3)) begin
            failures++;
            $display("FAIL tor_lock_prev got=%h exp=%h", bus.csr_rdata, m_read(1, 3));
        end
        csr_wr(0, 9, 32'hFF);
        csr_look(0, 9);
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL idx_oob got=%h exp=0", bus.csr_rdata);
        end
        access(1, 1, 32'h804, 1, 1, 32'h1800);
        access(1, 0, 0, 1, 0, 32'h1400);
        checks++;
        if (bus.trap_cause !== 4'd5 || bus.trap_addr !== 32'h1400) begin
            failures++;
            $display("FAIL m_locked cause=%0d addr=%h exp=5 00001400", bus.trap_cause, bus.trap_addr);
        end
        finish_trap();
    endtask

    task automatic test_same_cycle();
        apply_reset();
        access(0, 1, 32'h40, 1, 1, 32'h80);
        checks++;
        if (bus.trap_cause !== 4'd7 || bus.trap_addr !== 32'h80 || bus.violation_count !== exp_cnt()) begin
            failures++;
            $display("FAIL same_cycle cause=%0d addr=%h cnt=%0d exp=7 00000080 %0d",
                     bus.trap_cause, bus.trap_addr, bus.violation_count, exp_cnt());
        end
        access(0, 0, 0, 1, 0, 32'h40);
        checks++;
        if (bus.trap_cause !== 4'd7 || bus.trap_addr !== 32'h80 || bus.violation_count !== exp_cnt()) begin
            failures++;
            $display("FAIL frozen cause=%0d addr=%h cnt=%0d exp=7 00000080 %0d",
                     bus.trap_cause, bus.trap_addr, bus.violation_count, exp_cnt());
        end
        finish_trap();
    endtask

    task automatic test_back_to_back();
        bit got, iv, dv, dw, vi, vd;
        logic [31:0] ia, da, fa;
        logic [3:0] fc;
        csr_wr(1, 0, 32'h7FF);
        csr_wr(0, 0, 32'h1F);
        got = 0; fa = 0; fc = 0;
        for (int n = 0; n < 24; n++) begin
            iv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ia = 32'($urandom_range(0, 16'h1FFF)) << 2;
            da = 32'($urandom_range(0, 16'h1FFF)) << 2;
            vi = iv && !m_allow(ia[31:2], 2, 0);
            vd = dv && !m_allow(da[31:2], dw ? 1 : 0, 0);
            if (!got && vd) begin
                got = 1; fa = da; fc = dw ? 4'd7 : 4'd5;
            end else if (!got && vi) begin
                got = 1; fa = ia; fc = 4'd1;
            end
            access(0, iv, ia, dv, dw, da);
        end
        checks++;
        if (bus.trap_req !== got || bus.trap_cause !== fc || bus.trap_addr !== fa) begin
            failures++;
            $display("FAIL b2b_first req=%b cause=%0d addr=%h exp=%b %0d %h",
                     bus.trap_req, bus.trap_cause, bus.trap_addr, got, fc, fa);
        end
        checks++;
        if (bus.violation_count !== exp_cnt()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", bus.violation_count, exp_cnt());
        end
        finish_trap();
    endtask

    task automatic test_reset_mid_trap();
        access(0, 1, 32'h8000, 0, 0, 0);
        checks++;
        if (bus.trap_req !== 1) begin
            failures++;
            $display("FAIL pre_reset_trap req=%b exp=1", bus.trap_req);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({bus.instr_pmp_ok, bus.data_pmp_ok, bus.stall, bus.trap_req} !== 4'b1100 ||
            bus.trap_cause !== 4'd0 || bus.trap_addr !== 32'd0 || bus.violation_count !== 16'd0) begin
            failures++;
            $display("FAIL async_reset flags=%b cause=%0d addr=%h cnt=%0d exp=1100 0 0 0",
                     {bus.instr_pmp_ok, bus.data_pmp_ok, bus.stall, bus.trap_req},
                     bus.trap_cause, bus.trap_addr, bus.violation_count);
        end
        csr_look(0, 0);
        checks++;
        if (bus.csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_cfg_clear got=%h exp=0", bus.csr_rdata);
        end
        step();
        rst_n = 1;
        model_clear();
        access(0, 1, 32'h100, 0, 0, 0);
        checks++;
        if (bus.trap_req !== 1 || bus.trap_cause !== 4'd1 || bus.trap_addr !== 32'h100) begin
            failures++;
            $display("FAIL restart req=%b cause=%0d addr=%h exp=1 1 00000100",
                     bus.trap_req, bus.trap_cause, bus.trap_addr);
        end
        finish_trap();
        checks++;
        if (bus.stall !== 0) begin
            failures++;
            $display("FAIL restart_drain stall=%b exp=0", bus.stall);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_no_entry_trap();
        test_tor();
        test_priority();
        test_lock();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
